dest_sink: RTL

// - Synthesizable consumer at the egress end of the Main->VC->D interconnect; pops the D0/D1 output FIFOs.
// - Round-robin arbitration; one pop per cycle. Counts received words per destination.
// - Checks that each word's destination bit matches the FIFO it was read from.
// - Signals completion after an expected word total; stops on any FIFO error or misroute.

---
 rtl/dest_sink_pkg.sv | 24 ++
 rtl/dest_sink_if.sv | 30 +++
 rtl/dest_sink_rr_arb2.sv | 36 +++
 rtl/dest_sink.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dest_sink_pkg.sv
// Shared definitions for the D-side egress sink: FSM encoding and word field positions.
package dest_sink_pkg;

  localparam int unsigned BW_DEF    = 6;
  localparam int unsigned CNT_W_DEF = 5;

  // Word layout: [5:4] class field, bit 4 selects destination D0(0)/D1(1)
  localparam int unsigned CLASS_MSB = 5;
  localparam int unsigned CLASS_LSB = 4;
  localparam int unsigned DEST_BIT  = CLASS_LSB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  typedef enum logic {
    SRC_D0 = 1'b0,
    SRC_D1 = 1'b1
  } src_e;

endpackage

// File: rtl/dest_sink_if.sv
// FIFO-side bus between the D0/D1 output FIFOs (master) and the sink (slave).
interface dest_sink_if #(
  parameter int unsigned BW = 6
);

  logic          D0_empty;
  logic          D0_error_output;
  logic [BW-1:0] D0_data_out;
  logic          D0_rd;

  logic          D1_empty;
  logic          D1_error_output;
  logic [BW-1:0] D1_data_out;
  logic          D1_rd;

  // FIFO side: presents status and read data, receives pop strobes
  modport master (
    output D0_empty, D0_error_output, D0_data_out,
    output D1_empty, D1_error_output, D1_data_out,
    input  D0_rd, D1_rd
  );

  // Sink side: consumes status and read data, issues pop strobes
  modport slave (
    input  D0_empty, D0_error_output, D0_data_out,
    input  D1_empty, D1_error_output, D1_data_out,
    output D0_rd, D1_rd
  );

endinterface

// File: rtl/dest_sink_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer only moves when both request.
module dest_sink_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // Grant the pointed-to requester on contention, otherwise the lone requester
  always_comb begin
    ptr_d = ptr_q;
    gnt   = 2'b00;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
      if (adv) begin
        ptr_d = ~ptr_q;
      end
    end else begin
      gnt = req;
    end
  end

  // Pointer register, starts on requester 0
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dest_sink.sv
// Egress consumer for the D0/D1 FIFOs: round-robin pops, one-stage capture,
// per-destination counters, destination check and completion tracking.
module dest_sink
  import dest_sink_pkg::*;
#(
  parameter int unsigned BW    = BW_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W:0]   expected_total,
  dest_sink_if.slave       fifo,
  output logic             word_valid,
  output logic [BW-1:0]    word_data,
  output logic             word_src,
  output logic [CNT_W-1:0] D0_count,
  output logic [CNT_W-1:0] D1_count,
  output logic             done,
  output logic             misroute_err,
  output logic             fifo_err
);

  localparam int unsigned TOT_W = CNT_W + 1;

  state_e             state_q, state_d;
  logic [TOT_W-1:0]   expected_q, expected_d;
  logic [TOT_W-1:0]   issued_q, issued_d;
  logic               pend_v_q, pend_v_d;
  logic               pend_src_q, pend_src_d;
  logic               word_valid_q, word_valid_d;
  logic [BW-1:0]      word_data_q, word_data_d;
  logic               word_src_q, word_src_d;
  logic [CNT_W-1:0]   d0_cnt_q, d0_cnt_d;
  logic [CNT_W-1:0]   d1_cnt_q, d1_cnt_d;
  logic               done_q, done_d;
  logic               misroute_q, misroute_d;
  logic               fifo_err_q, fifo_err_d;

  logic               err_in_c;
  logic               can_pop_c;
  logic [1:0]         req_c;
  logic [1:0]         gnt_c;
  logic               pop_c;
  logic [BW-1:0]      cap_word_c;
  logic               misroute_c;

  // Pop eligibility: running, below the expected total, and no FIFO fault this cycle
  always_comb begin
    err_in_c   = fifo.D0_error_output | fifo.D1_error_output;
    can_pop_c  = (state_q == S_RUN) && enable && (issued_q < expected_q) && !err_in_c;
    req_c      = {~fifo.D1_empty, ~fifo.D0_empty} & {2{can_pop_c}};
    pop_c      = |gnt_c;
    cap_word_c = pend_src_q ? fifo.D1_data_out : fifo.D0_data_out;
    misroute_c = pend_v_q && (cap_word_c[DEST_BIT] != pend_src_q);
  end

  dest_sink_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req_c),
    .adv   (can_pop_c),
    .gnt   (gnt_c)
  );

  assign fifo.D0_rd = gnt_c[0];
  assign fifo.D1_rd = gnt_c[1];

  // Next-state: capture stage, counters, sticky flags and FSM transitions
  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    issued_d     = issued_q;
    pend_v_d     = pop_c;
    pend_src_d   = gnt_c[1];
    word_valid_d = 1'b0;
    word_data_d  = word_data_q;
    word_src_d   = word_src_q;
    d0_cnt_d     = d0_cnt_q;
    d1_cnt_d     = d1_cnt_q;
    misroute_d   = misroute_q;
    fifo_err_d   = fifo_err_q;

    if (pop_c) begin
      issued_d = issued_q + TOT_W'(1);
    end

    // A pending read completes in any state, including ERR
    if (pend_v_q) begin
      word_valid_d = 1'b1;
      word_data_d  = cap_word_c;
      word_src_d   = pend_src_q;
      if (pend_src_q == SRC_D0) begin
        if (d0_cnt_q != {CNT_W{1'b1}}) begin
          d0_cnt_d = d0_cnt_q + CNT_W'(1);
        end
      end else begin
        if (d1_cnt_q != {CNT_W{1'b1}}) begin
          d1_cnt_d = d1_cnt_q + CNT_W'(1);
        end
      end
      if (misroute_c) begin
        misroute_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d    = S_RUN;
          expected_d = expected_total;
          issued_d   = '0;
          d0_cnt_d   = '0;
          d1_cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (err_in_c) begin
          fifo_err_d = 1'b1;
          state_d    = S_ERR;
        end else if (misroute_c) begin
          state_d = S_ERR;
        end else if ((issued_q == expected_q) && !pend_v_d) begin
          state_d = S_DONE;
        end else if (!enable && !pend_v_d) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset drops any in-flight read
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      expected_q   <= '0;
      issued_q     <= '0;
      pend_v_q     <= 1'b0;
      pend_src_q   <= 1'b0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
      word_src_q   <= 1'b0;
      d0_cnt_q     <= '0;
      d1_cnt_q     <= '0;
      done_q       <= 1'b0;
      misroute_q   <= 1'b0;
      fifo_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      issued_q     <= issued_d;
      pend_v_q     <= pend_v_d;
      pend_src_q   <= pend_src_d;
      word_valid_q <= word_valid_d;
      word_data_q  <= word_data_d;
      word_src_q   <= word_src_d;
      d0_cnt_q     <= d0_cnt_d;
      d1_cnt_q     <= d1_cnt_d;
      done_q       <= done_d;
      misroute_q   <= misroute_d;
      fifo_err_q   <= fifo_err_d;
    end
  end

  assign word_valid   = word_valid_q;
  assign word_data    = word_data_q;
  assign word_src     = word_src_q;
  assign D0_count     = d0_cnt_q;
  assign D1_count     = d1_cnt_q;
  assign done         = done_q;
  assign misroute_err = misroute_q;
  assign fifo_err     = fifo_err_q;

endmodule
